// File: rtl/auth_pkg.sv
// Shared types and constants for the player login stage: state encodings,
// the password table and the match helper.
package auth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_PW    = 3'd1,
        ST_CHECK     = 3'd2,
        ST_LOGGED_IN = 3'd3,
        ST_LOCKED    = 3'd4
    } auth_state_e;

    localparam int DIGITS = 4;

    localparam logic [15:0] PW_TABLE [16] = '{
        1: 16'h1234,
        2: 16'h0000,
        3: 16'h9876,
        default: 16'h0000
    };

    localparam bit PW_VALID [16] = '{
        1: 1'b1,
        2: 1'b1,
        3: 1'b1,
        default: 1'b0
    };

    function automatic logic pw_match(input logic [3:0] id, input logic [15:0] pw);
        return PW_VALID[id] && (PW_TABLE[id] == pw);
    endfunction

endpackage

// File: rtl/auth_lock_timer.sv
// Lockout countdown: after load, busy stays high for exactly LOCK_CYCLES
// cycles and done marks the last of them.
module auth_lock_timer #(
    parameter int LOCK_CYCLES = 150000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy,
    output logic done
);

    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          run_q, run_d;

    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        if (load) begin
            count_d = CW'(LOCK_CYCLES - 1);
            run_d   = 1'b1;
        end else if (run_q) begin
            if (count_q == '0) begin
                run_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

    assign busy = run_q;
    assign done = run_q && (count_q == '0);

endmodule

// File: rtl/auth_login.sv
// Player login FSM: ID nibble then four password digits, checked against
// auth_pkg::PW_TABLE. AUTH_LOCKOUT_EN enables the retry counter and lockout.
module auth_login
    import auth_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 150000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] SwPass,
    input  logic       BtPass,
    input  logic       GameBusy,
    output logic       AuthLoggedIn,
    output logic [4:0] AuthPlayerID,
    output logic       AuthFail,
    output logic       AuthLocked,
    output logic [2:0] AuthState
);

    auth_state_e state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [15:0] pw_q, pw_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        logged_q, logged_d;
    logic [4:0]  pid_q, pid_d;
    logic        fail_q, fail_d;

`ifdef AUTH_LOCKOUT_EN
    localparam int TW = $clog2(MAX_TRIES + 1);
    logic [TW-1:0] tries_q, tries_d;
    logic          lock_load, lock_busy, lock_done;

    auth_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
        .clk   (Clk),
        .rst_n (Rst),
        .load  (lock_load),
        .busy  (lock_busy),
        .done  (lock_done)
    );

    assign AuthLocked = lock_busy;
`else
    assign AuthLocked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        pw_d     = pw_q;
        cnt_d    = cnt_q;
        logged_d = logged_q;
        pid_d    = pid_q;
        fail_d   = 1'b0;
`ifdef AUTH_LOCKOUT_EN
        tries_d   = tries_q;
        lock_load = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (BtPass && (SwPass != 4'd0)) begin
                    id_d    = SwPass;
                    cnt_d   = 2'd0;
                    pw_d    = 16'h0000;
                    state_d = ST_GET_PW;
                end
            end
            ST_GET_PW: begin
                if (BtPass) begin
                    pw_d  = {pw_q[11:0], SwPass};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(DIGITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (pw_match(id_q, pw_q)) begin
                    state_d  = ST_LOGGED_IN;
                    logged_d = 1'b1;
                    pid_d    = {1'b0, id_q};
`ifdef AUTH_LOCKOUT_EN
                    tries_d  = '0;
`endif
                end else begin
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef AUTH_LOCKOUT_EN
                    // Saturate so a misconfigured MAX_TRIES can never wrap to zero.
                    if (int'(tries_q) < MAX_TRIES) begin
                        tries_d = tries_q + 1'b1;
                    end
                    if (int'(tries_q) + 1 >= MAX_TRIES) begin
                        state_d   = ST_LOCKED;
                        lock_load = 1'b1;
                    end
`endif
                end
            end
            ST_LOGGED_IN: begin
                if (BtPass && !GameBusy) begin
                    state_d  = ST_IDLE;
                    logged_d = 1'b0;
                    pid_d    = 5'd0;
                end
            end
`ifdef AUTH_LOCKOUT_EN
            ST_LOCKED: begin
                if (lock_done) begin
                    state_d = ST_IDLE;
                    tries_d = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            id_q     <= 4'd0;
            pw_q     <= 16'h0000;
            cnt_q    <= 2'd0;
            logged_q <= 1'b0;
            pid_q    <= 5'd0;
            fail_q   <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
            tries_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            pw_q     <= pw_d;
            cnt_q    <= cnt_d;
            logged_q <= logged_d;
            pid_q    <= pid_d;
            fail_q   <= fail_d;
`ifdef AUTH_LOCKOUT_EN
            tries_q  <= tries_d;
`endif
        end
    end

    assign AuthLoggedIn = logged_q;
    assign AuthPlayerID = pid_q;
    assign AuthFail     = fail_q;
    assign AuthState    = state_q;

endmodule
